// File: rtl/sprite_anim_sequencer.sv
// Per-player sprite animation sequencer: frame-aligned sprite-state select with multi-frame attacks.
// Optional SPRITE_FREEZE_EN adds a freeze input that suspends frame ticks.
module sprite_anim_sequencer #(
  parameter int unsigned START_FRAMES   = 2,
  parameter int unsigned ACTIVE_FRAMES  = 3,
  parameter int unsigned RECOVER_FRAMES = 2,
  parameter int unsigned HIT_FRAMES     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       mv_fwd,
  input  logic       mv_back,
  input  logic       blk,
  input  logic       req_attack,
  input  logic       req_dirattack,
  input  logic       got_hit,
`ifdef SPRITE_FREEZE_EN
  input  logic       freeze,
`endif
  output logic [3:0] sprite_state,
  output logic       attack_active,
  output logic       busy,
  output logic       seq_done
);

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StWalk     = 4'd1,
    StWalkBack = 4'd2,
    StAtkStart = 4'd3,
    StAtkEnd   = 4'd4,
    StAtkPull  = 4'd5,
    StBlock    = 4'd6,
    StDirStart = 4'd7,
    StDirEnd   = 4'd8,
    StDirPull  = 4'd9,
    StGotHit   = 4'd10
  } state_e;

  localparam logic [7:0] StartLoad   = 8'(START_FRAMES - 1);
  localparam logic [7:0] ActiveLoad  = 8'(ACTIVE_FRAMES - 1);
  localparam logic [7:0] RecoverLoad = 8'(RECOVER_FRAMES - 1);
  localparam logic [7:0] HitLoad     = 8'(HIT_FRAMES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       atk_pend_q, atk_pend_d;
  logic       dir_pend_q, dir_pend_d;
  logic       hit_pend_q, hit_pend_d;
  logic       attack_active_q, busy_q, seq_done_q, seq_done_d;
  logic       tick_en;
  logic       atk_eff, dir_eff, hit_eff;

  function automatic logic is_busy(input state_e s);
    case (s)
      StAtkStart, StAtkEnd, StAtkPull,
      StDirStart, StDirEnd, StDirPull, StGotHit: is_busy = 1'b1;
      default:                                   is_busy = 1'b0;
    endcase
  endfunction

`ifdef SPRITE_FREEZE_EN
  assign tick_en = frame_tick & ~freeze;
`else
  assign tick_en = frame_tick;
`endif

  // A request in the same cycle as a tick takes part in that tick's evaluation.
  assign atk_eff = atk_pend_q | req_attack;
  assign dir_eff = dir_pend_q | req_dirattack;
  assign hit_eff = hit_pend_q | got_hit;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    seq_done_d = 1'b0;
    atk_pend_d = atk_eff;
    dir_pend_d = dir_eff;
    hit_pend_d = hit_eff;
    if (tick_en) begin
      // Every tick consumes or drops all pending requests.
      atk_pend_d = 1'b0;
      dir_pend_d = 1'b0;
      hit_pend_d = 1'b0;
      if (hit_eff) begin
        state_d = StGotHit;
        cnt_d   = HitLoad;
      end else if (is_busy(state_q) && (cnt_q != 8'd0)) begin
        cnt_d = cnt_q - 8'd1;
      end else begin
        case (state_q)
          StAtkStart: begin
            state_d = StAtkEnd;
            cnt_d   = ActiveLoad;
          end
          StAtkEnd: begin
            state_d = StAtkPull;
            cnt_d   = RecoverLoad;
          end
          StDirStart: begin
            state_d = StDirEnd;
            cnt_d   = ActiveLoad;
          end
          StDirEnd: begin
            state_d = StDirPull;
            cnt_d   = RecoverLoad;
          end
          default: begin
            seq_done_d = (state_q == StAtkPull) || (state_q == StDirPull);
            cnt_d      = 8'd0;
            if (atk_eff) begin
              state_d = StAtkStart;
              cnt_d   = StartLoad;
            end else if (dir_eff) begin
              state_d = StDirStart;
              cnt_d   = StartLoad;
            end else if (blk) begin
              state_d = StBlock;
            end else if (mv_fwd) begin
              state_d = StWalk;
            end else if (mv_back) begin
              state_d = StWalkBack;
            end else begin
              state_d = StIdle;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= 8'd0;
      atk_pend_q      <= 1'b0;
      dir_pend_q      <= 1'b0;
      hit_pend_q      <= 1'b0;
      attack_active_q <= 1'b0;
      busy_q          <= 1'b0;
      seq_done_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      atk_pend_q      <= atk_pend_d;
      dir_pend_q      <= dir_pend_d;
      hit_pend_q      <= hit_pend_d;
      attack_active_q <= (state_d == StAtkEnd) || (state_d == StDirEnd);
      busy_q          <= is_busy(state_d);
      seq_done_q      <= seq_done_d;
    end
  end

  assign sprite_state  = state_q;
  assign attack_active = attack_active_q;
  assign busy          = busy_q;
  assign seq_done      = seq_done_q;

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Bench for sprite_anim_sequencer: directed scenarios plus random traffic against a phase-queue model.
module tb_sprite_anim_sequencer;

  localparam int S = 2;
  localparam int A = 3;
  localparam int R = 2;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       mv_fwd = 1'b0, mv_back = 1'b0, blk = 1'b0;
  logic       req_attack = 1'b0, req_dirattack = 1'b0, got_hit = 1'b0;
  logic       freeze = 1'b0;
  logic [3:0] sprite_state;
  logic       attack_active, busy, seq_done;

  int n_checks = 0;
  int n_errors = 0;

  // Model: current displayed state, frames it still has to show, queue of upcoming phases.
  int m_state = 0;
  int m_rem = 0;
  int q_st[$];
  int q_fr[$];
  bit m_pa = 0, m_pd = 0, m_ph = 0, m_done = 0;

  always #5 clk = ~clk;

  sprite_anim_sequencer #(
    .START_FRAMES  (S),
    .ACTIVE_FRAMES (A),
    .RECOVER_FRAMES(R),
    .HIT_FRAMES    (H)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .mv_fwd       (mv_fwd),
    .mv_back      (mv_back),
    .blk          (blk),
    .req_attack   (req_attack),
    .req_dirattack(req_dirattack),
    .got_hit      (got_hit),
`ifdef SPRITE_FREEZE_EN
    .freeze       (freeze),
`endif
    .sprite_state (sprite_state),
    .attack_active(attack_active),
    .busy         (busy),
    .seq_done     (seq_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    bit tick;
`ifdef SPRITE_FREEZE_EN
    tick = frame_tick && !freeze;
`else
    tick = frame_tick;
`endif
    m_done = 0;
    if (rst) begin
      m_state = 0; m_rem = 0; m_pa = 0; m_pd = 0; m_ph = 0;
      q_st.delete(); q_fr.delete();
      return;
    end
    m_pa |= req_attack;
    m_pd |= req_dirattack;
    m_ph |= got_hit;
    if (!tick) return;
    if (m_ph) begin
      m_state = 10; m_rem = H;
      q_st.delete(); q_fr.delete();
    end else if (m_rem > 1) begin
      m_rem--;
    end else if (q_st.size() > 0) begin
      m_state = q_st.pop_front();
      m_rem   = q_fr.pop_front();
    end else begin
      m_done = (m_state == 5) || (m_state == 9);
      m_rem  = 0;
      if (m_pa) begin
        m_state = 3; m_rem = S;
        q_st = '{4, 5}; q_fr = '{A, R};
      end else if (m_pd) begin
        m_state = 7; m_rem = S;
        q_st = '{8, 9}; q_fr = '{A, R};
      end else if (blk) m_state = 6;
      else if (mv_fwd) m_state = 1;
      else if (mv_back) m_state = 2;
      else m_state = 0;
    end
    m_pa = 0; m_pd = 0; m_ph = 0;
  endtask

  // One clock: model follows the edge, outputs compared 1ns later, then pulses are dropped.
  task automatic step();
    bit exp_busy, exp_act;
    @(posedge clk);
    model_update();
    #1;
    exp_act  = (m_state == 4) || (m_state == 8);
    exp_busy = (m_state >= 3 && m_state <= 5) || (m_state >= 7 && m_state <= 10);
    check_eq("state", 32'(sprite_state), m_state);
    check_eq("attack_active", 32'(attack_active), 32'(exp_act));
    check_eq("busy", 32'(busy), 32'(exp_busy));
    check_eq("seq_done", 32'(seq_done), 32'(m_done));
    frame_tick = 0; req_attack = 0; req_dirattack = 0; got_hit = 0;
  endtask

  // One tick followed by two quiet cycles.
  task automatic tick1();
    frame_tick = 1;
    step();
    step();
    step();
  endtask

  int t2_exp[8] = '{3, 3, 4, 4, 4, 5, 5, 0};
  int done_cnt;

  initial begin
    // T1: reset
    rst = 1; step(); step();
    check_eq("t1_state", 32'(sprite_state), 0);
    check_eq("t1_done", 32'(seq_done), 0);
    rst = 0; step();

    // T2: full attack sequence
    req_attack = 1; step();
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      frame_tick = 1; step();
      check_eq("t2_state", 32'(sprite_state), 32'(t2_exp[i]));
      check_eq("t2_active", 32'(attack_active), 32'(t2_exp[i] == 4));
      done_cnt += int'(seq_done);
      step(); step();
      done_cnt += int'(seq_done);
    end
    check_eq("t2_done_count", 32'(done_cnt), 1);

    // T3: hit during second ATK_END frame
    req_attack = 1; step();
    for (int i = 0; i < 4; i++) tick1();
    check_eq("t3_pre", 32'(sprite_state), 4);
    got_hit = 1; step();
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      frame_tick = 1; step();
      check_eq("t3_state", 32'(sprite_state), (i < 4) ? 10 : 0);
      check_eq("t3_active", 32'(attack_active), 0);
      done_cnt += int'(seq_done);
      step();
    end
    check_eq("t3_no_done", 32'(done_cnt), 0);

    // T4: both attack requests together
    req_attack = 1; req_dirattack = 1; step();
    tick1();
    check_eq("t4_first", 32'(sprite_state), 3);
    for (int i = 0; i < 8; i++) tick1();
    check_eq("t4_after", 32'(sprite_state), 0);

    // T5: block beats walk
    blk = 1; mv_fwd = 1;
    tick1(); check_eq("t5_blk1", 32'(sprite_state), 6);
    tick1(); check_eq("t5_blk2", 32'(sprite_state), 6);
    blk = 0;
    tick1(); check_eq("t5_walk", 32'(sprite_state), 1);
    mv_fwd = 0; tick1();

`ifdef SPRITE_FREEZE_EN
    // T6: freeze in ATK_END holds state and counter
    req_attack = 1; step();
    for (int i = 0; i < 3; i++) tick1();
    freeze = 1;
    for (int i = 0; i < 5; i++) begin
      tick1();
      check_eq("t6_frozen", 32'(sprite_state), 4);
    end
    freeze = 0;
    for (int i = 0; i < 5; i++) begin
      tick1();
      check_eq("t6_resume", 32'(sprite_state), (i < 2) ? 4 : ((i < 4) ? 5 : 0));
    end
`endif

    // Random traffic against the model
    for (int i = 0; i < 6000; i++) begin
      frame_tick    = ($urandom_range(0, 3) == 0);
      req_attack    = ($urandom_range(0, 24) == 0);
      req_dirattack = ($urandom_range(0, 24) == 0);
      got_hit       = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 39) == 0) blk = ~blk;
      if ($urandom_range(0, 29) == 0) mv_fwd = ~mv_fwd;
      if ($urandom_range(0, 29) == 0) mv_back = ~mv_back;
      freeze = ($urandom_range(0, 5) == 0);
      rst    = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 0; freeze = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
